// File: rtl/xalu_ise_iter.sv
// Custom-instruction unit: rotate-right, xnor and funnel shifts for a RISC-V core.
// Operands go into a 64-bit work register that is shifted either at once or STEP bits per cycle.
module xalu_ise_iter #(
  parameter logic [2:0] ISE_V = 3'b111,
  parameter int         ITER  = 1,
  parameter int         STEP  = 4
) (
  input  logic        ise_clk,
  input  logic        ise_rst,
  input  logic [4:0]  ise_fn,
  input  logic [6:0]  ise_imm,
  input  logic [31:0] ise_in1,
  input  logic [31:0] ise_in2,
  input  logic        ise_val,
  output logic        ise_rdy,
  output logic        ise_oval,
  output logic [31:0] ise_out
);

  // state | meaning
  // IDLE  | ready, waiting for a supported request
  // SHIFT | iterative shift of W until R reaches zero
  // DONE  | one-cycle result pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP_C = 5'(STEP);

  state_t      r_state, w_state_nxt;
  logic [63:0] r_w, w_w_nxt, w_cap_w;
  logic [4:0]  r_r, w_r_nxt, w_cap_r, w_amt, w_fixed_n;
  logic        w_rori, w_xnor, w_fsri, w_fsrn, w_sup, w_acc;
  logic        w_unused;

  // only the low two opcode bits distinguish CUSTOM_0..3
  assign w_unused = ^ise_fn[4:2];

  assign w_rori = ISE_V[0] && (ise_fn[1:0] == 2'd0) && (ise_imm[6:5] == 2'b00);
  assign w_xnor = ISE_V[0] && (ise_fn[1:0] == 2'd2) && (ise_imm == 7'd0);
  assign w_fsri = ISE_V[1] && (ise_fn[1:0] == 2'd1) && (ise_imm[6:5] == 2'b00);
  assign w_fsrn = ISE_V[2] && (ise_fn[1:0] == 2'd3) && (ise_imm[6:2] == 5'd0);
  assign w_sup  = w_rori || w_xnor || w_fsri || w_fsrn;
  assign w_acc  = (r_state == IDLE) && ise_val && w_sup;

  always_comb begin
    case (ise_imm[1:0])
      2'd0:    w_fixed_n = 5'd15;
      2'd1:    w_fixed_n = 5'd6;
      2'd2:    w_fixed_n = 5'd21;
      default: w_fixed_n = 5'd27;
    endcase
  end

  always_comb begin
    w_cap_w = {ise_in2, ise_in1};
    w_cap_r = w_fixed_n;
    if (w_rori) begin
      w_cap_w = {ise_in1, ise_in1};
      w_cap_r = ise_imm[4:0];
    end else if (w_fsri) begin
      w_cap_r = ise_imm[4:0];
    end else if (w_xnor) begin
      w_cap_w = {32'd0, ~(ise_in1 ^ ise_in2)};
      w_cap_r = 5'd0;
    end
  end

  // last step may be shorter than STEP so R lands exactly on zero
  assign w_amt = (r_r < STEP_C) ? r_r : STEP_C;

  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_r_nxt     = r_r;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (ITER == 0) begin
            w_w_nxt     = w_cap_w >> w_cap_r;
            w_r_nxt     = 5'd0;
            w_state_nxt = DONE;
          end else begin
            w_w_nxt     = w_cap_w;
            w_r_nxt     = w_cap_r;
            w_state_nxt = (w_cap_r == 5'd0) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        w_w_nxt = r_w >> w_amt;
        w_r_nxt = r_r - w_amt;
        if (r_r == w_amt) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      r_state <= IDLE;
      r_w     <= 64'd0;
      r_r     <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_w     <= w_w_nxt;
      r_r     <= w_r_nxt;
    end
  end

  // reset gates the outputs so an aborted operation can never pulse
  assign ise_rdy  = (r_state == IDLE) && !ise_rst;
  assign ise_oval = (r_state == DONE) && !ise_rst;
  assign ise_out  = ise_oval ? r_w[31:0] : 32'd0;

endmodule

// File: tb/tb_xalu_ise_iter.sv
// Bench for xalu_ise_iter: six configurations share one request stream and are
// compared against a behavioural model of the instruction semantics and latency.
module tb_xalu_ise_iter;

  localparam int ND = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  fn  = '0;
  logic [6:0]  imm = '0;
  logic [31:0] in1 = '0, in2 = '0;
  logic        val = 1'b0;
  logic        d_rdy [ND];
  logic        d_oval[ND];
  logic [31:0] d_out [ND];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xalu_ise_iter #(.ISE_V(3'b111), .ITER(0), .STEP(4)) u_i0 (.ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
    .ise_in1(in1), .ise_in2(in2), .ise_val(val), .ise_rdy(d_rdy[0]), .ise_oval(d_oval[0]), .ise_out(d_out[0]));
  xalu_ise_iter #(.ISE_V(3'b111), .ITER(1), .STEP(1)) u_s1 (.ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
    .ise_in1(in1), .ise_in2(in2), .ise_val(val), .ise_rdy(d_rdy[1]), .ise_oval(d_oval[1]), .ise_out(d_out[1]));
  xalu_ise_iter #(.ISE_V(3'b111), .ITER(1), .STEP(2)) u_s2 (.ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
    .ise_in1(in1), .ise_in2(in2), .ise_val(val), .ise_rdy(d_rdy[2]), .ise_oval(d_oval[2]), .ise_out(d_out[2]));
  xalu_ise_iter #(.ISE_V(3'b111), .ITER(1), .STEP(4)) u_s4 (.ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
    .ise_in1(in1), .ise_in2(in2), .ise_val(val), .ise_rdy(d_rdy[3]), .ise_oval(d_oval[3]), .ise_out(d_out[3]));
  xalu_ise_iter #(.ISE_V(3'b111), .ITER(1), .STEP(8)) u_s8 (.ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
    .ise_in1(in1), .ise_in2(in2), .ise_val(val), .ise_rdy(d_rdy[4]), .ise_oval(d_oval[4]), .ise_out(d_out[4]));
  xalu_ise_iter #(.ISE_V(3'b110), .ITER(1), .STEP(4)) u_dis (.ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
    .ise_in1(in1), .ise_in2(in2), .ise_val(val), .ise_rdy(d_rdy[5]), .ise_oval(d_oval[5]), .ise_out(d_out[5]));

  function automatic int cfg_iter(int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int cfg_step(int d);
    case (d)
      1: return 1;
      2: return 2;
      4: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] cfg_v(int d);
    return (d == 5) ? 3'b110 : 3'b111;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Instruction semantics: acceptance, result and remaining shift count.
  function automatic void model(input logic [4:0] f, input logic [6:0] im, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] v, output bit ok, output logic [31:0] res, output int n);
    logic [63:0] cat;
    ok  = 1'b0;
    res = '0;
    n   = 0;
    cat = {b, a};
    case (f[1:0])
      2'd0: if (v[0] && im[6:5] == 2'b00) begin
        ok  = 1'b1;
        n   = int'(im[4:0]);
        res = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      end
      2'd2: if (v[0] && im == 7'd0) begin
        ok  = 1'b1;
        res = ~(a ^ b);
      end
      2'd1: if (v[1] && im[6:5] == 2'b00) begin
        ok  = 1'b1;
        n   = int'(im[4:0]);
        res = 32'(cat >> n);
      end
      default: if (v[2] && im <= 7'd3) begin
        ok = 1'b1;
        case (im[1:0])
          2'd0: n = 15;
          2'd1: n = 6;
          2'd2: n = 21;
          default: n = 27;
        endcase
        res = 32'(cat >> n);
      end
    endcase
  endfunction

  // One request presented for a single cycle to all DUTs while they are idle.
  task automatic run_op(input string tag, input logic [4:0] f, input logic [6:0] im,
                        input logic [31:0] a, input logic [31:0] b);
    bit          ok  [ND];
    logic [31:0] exp [ND];
    int          lat [ND];
    int          first[ND];
    int          pulses[ND];
    int          bad_rdy[ND];
    int          junk[ND];
    logic [31:0] got [ND];
    int          n;
    for (int d = 0; d < ND; d++) begin
      model(f, im, a, b, cfg_v(d), ok[d], exp[d], n);
      lat[d]   = (cfg_iter(d) == 0) ? 1 : 1 + (n + cfg_step(d) - 1) / cfg_step(d);
      first[d] = -1; pulses[d] = 0; bad_rdy[d] = 0; junk[d] = 0; got[d] = '0;
    end
    @(negedge clk);
    fn = f; imm = im; in1 = a; in2 = b; val = 1'b1;
    @(posedge clk);
    #1;
    val = 1'b0;
    fn  = 5'($urandom); imm = 7'($urandom); in1 = $urandom; in2 = $urandom;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (d_oval[d]) begin
          pulses[d]++;
          if (first[d] < 0) begin
            first[d] = k;
            got[d]   = d_out[d];
          end
        end else if (d_out[d] != 32'd0) begin
          junk[d]++;
        end
        if (ok[d] && k <= lat[d] && d_rdy[d]) bad_rdy[d]++;
        if ((!ok[d] || k > lat[d]) && !d_rdy[d]) bad_rdy[d]++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s d%0d pulses", tag, d), 32'(pulses[d]), ok[d] ? 32'd1 : 32'd0);
      check($sformatf("%s d%0d rdy", tag, d), 32'(bad_rdy[d]), 32'd0);
      check($sformatf("%s d%0d idle_out", tag, d), 32'(junk[d]), 32'd0);
      if (ok[d]) begin
        check($sformatf("%s d%0d latency", tag, d), 32'(first[d]), 32'(lat[d]));
        check($sformatf("%s d%0d result", tag, d), got[d], exp[d]);
      end
    end
  endtask

  task automatic expect_result(input string tag, input int d, input logic [31:0] r, input int l);
    logic [31:0] res;
    bit          ok;
    int          n;
    model(fn, imm, in1, in2, cfg_v(d), ok, res, n);
    check({tag, " const"}, res, r);
    check({tag, " lat"}, (cfg_iter(d) == 0) ? 32'd1 : 32'(1 + (n + cfg_step(d) - 1) / cfg_step(d)), 32'(l));
  endtask

  initial begin
    int pulses_after;
    int sel;
    logic [4:0] f;
    logic [6:0] im;

    // reset state
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        check($sformatf("rst d%0d out", d), d_out[d], 32'd0);
        check($sformatf("rst d%0d flags", d), {30'd0, d_rdy[d], d_oval[d]}, 32'd0);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check($sformatf("post_rst d%0d rdy", d), 32'(d_rdy[d]), 32'd1);

    // model sanity against the worked examples
    fn = 5'd0; imm = 7'd1;  in1 = 32'h80000001; in2 = 32'h0;
    expect_result("ex_rori", 3, 32'hC0000000, 2);
    fn = 5'd3; imm = 7'd0;  in1 = 32'h0;        in2 = 32'h1;
    expect_result("ex_fsr15", 3, 32'h00020000, 5);
    fn = 5'd1; imm = 7'd31; in1 = 32'hFFFFFFFF; in2 = 32'h0;
    expect_result("ex_fsri31", 3, 32'h00000001, 9);

    run_op("rori",   5'd0, 7'd1,  32'h80000001, 32'h12345678);
    run_op("xnor",   5'd2, 7'd0,  32'hFFFF0000, 32'h0F0F0F0F);
    run_op("fsr15",  5'd3, 7'd0,  32'h00000000, 32'h00000001);
    run_op("fsr06",  5'd3, 7'd1,  32'hDEADBEEF, 32'hCAFEF00D);
    run_op("fsr21",  5'd3, 7'd2,  32'hDEADBEEF, 32'hCAFEF00D);
    run_op("fsr27",  5'd3, 7'd3,  32'hDEADBEEF, 32'hCAFEF00D);
    run_op("fsri31", 5'd1, 7'd31, 32'hFFFFFFFF, 32'h00000000);
    run_op("rori0",  5'd0, 7'd0,  32'hA5A5A5A5, 32'h0);
    run_op("bad_fn3", 5'd3, 7'd4, 32'h1, 32'h2);
    run_op("bad_rori", 5'd0, 7'h21, 32'h1, 32'h2);

    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 5));
      f   = {3'($urandom), 2'd0};
      im  = 7'd0;
      case (sel)
        0: begin f[1:0] = 2'd0; im = {2'b00, 5'($urandom)}; end
        1: begin f[1:0] = 2'd1; im = {2'b00, 5'($urandom)}; end
        2: begin f[1:0] = 2'd2; end
        3: begin f[1:0] = 2'd3; im = 7'($urandom_range(0, 3)); end
        4: begin f = 5'($urandom); im = 7'($urandom); end
        default: begin f[1:0] = 2'($urandom_range(0, 1)); im = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'd31; end
      endcase
      run_op("rand", f, im, $urandom, $urandom);
    end

    // reset in the middle of a long funnel shift
    @(negedge clk);
    fn = 5'd1; imm = 7'd31; in1 = 32'hFFFFFFFF; in2 = 32'h0; val = 1'b1;
    @(posedge clk);
    #1;
    val = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses_after = 0;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) if (d_oval[d] || d_rdy[d]) pulses_after++;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check($sformatf("abort d%0d rdy", d), 32'(d_rdy[d]), 32'd1);
    repeat (35) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) if (d_oval[d]) pulses_after++;
    end
    check("abort no_oval", 32'(pulses_after), 32'd0);
    run_op("xnor_after", 5'd2, 7'd0, 32'h13579BDF, 32'h2468ACE0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
